// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// datapath widths.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_e;

  // States in which the host link may deliver bytes.
  function automatic logic accepts_bytes(input loader_state_e s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/byte_to_word.sv
// Host-link byte assembler. A byte transfers on a clock edge where
// rx_valid && rx_ready. The first byte of each pair is the high byte; the
// word is presented combinationally, together with word_valid, during the
// cycle in which the low byte transfers.
module byte_to_word
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               accept,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  logic              phase_hi_q, phase_hi_d;
  logic [BYTE_W-1:0] hi_byte_q, hi_byte_d;
  logic              xfer;

  // Handshake, phase toggle and high-byte capture.
  always_comb begin
    rx_ready   = accept;
    xfer       = rx_valid && accept;
    phase_hi_d = phase_hi_q;
    hi_byte_d  = hi_byte_q;
    if (clear) begin
      phase_hi_d = 1'b1;
    end else if (xfer) begin
      phase_hi_d = !phase_hi_q;
      if (phase_hi_q) begin
        hi_byte_d = rx_data;
      end
    end
    word_valid = xfer && !phase_hi_q;
    word       = {hi_byte_q, rx_data};
  end

  // Phase and high-byte registers; phase resets to "expecting high byte".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_hi_q <= 1'b1;
      hi_byte_q  <= '0;
    end else begin
      phase_hi_q <= phase_hi_d;
      hi_byte_q  <= hi_byte_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory port-2 writer. Receives a LEN / data / CSUM framed
// byte stream, writes each data word to BASE_ADDR + index (16-bit wrap),
// verifies the trailing checksum and holds the CPU while loading or in ERR.
// dbg_state exposes the FSM state for observation.
module instr_loader
  import cpu_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [15:0]        instr_addr2,
  output logic [INSTR_W-1:0] instr_data2,
  output logic               instr_Wen2,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [15:0]        words_loaded,
  output loader_state_e      dbg_state
);

  loader_state_e      state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        idx_q, idx_d;
  logic [INSTR_W-1:0] csum_q, csum_d;
  logic [15:0]        words_q, words_d;
  logic [15:0]        addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic               wen_q, wen_d;

  logic               b2w_clear;
  logic               b2w_accept;
  logic               word_valid;
  logic [INSTR_W-1:0] word;

  byte_to_word u_b2w (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (b2w_clear),
    .accept     (b2w_accept),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state and datapath updates; the write pulse lasts one cycle and
  // follows the low-byte transfer of each data word.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    words_d    = words_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wen_d      = 1'b0;
    b2w_clear  = 1'b0;
    b2w_accept = accepts_bytes(state_q);
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = LEN;
          csum_d    = '0;
          idx_d     = '0;
          words_d   = '0;
          b2w_clear = 1'b1;
        end
      end
      LEN: begin
        if (word_valid) begin
          len_d = word;
          if (word > MAX_WORDS) begin
            state_d = ERR;
          end else if (word == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          addr_d  = BASE_ADDR + idx_q;
          data_d  = word;
          wen_d   = 1'b1;
          csum_d  = csum_q + word;
          idx_d   = idx_q + 16'd1;
          words_d = words_q + 16'd1;
          if (idx_q == len_q - 16'd1) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (word_valid) begin
          state_d = (word == csum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      words_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    instr_addr2  = addr_q;
    instr_data2  = data_q;
    instr_Wen2   = wen_q;
    words_loaded = words_q;
    load_done    = (state_q == DONE);
    load_err     = (state_q == ERR);
    cpu_hold     = accepts_bytes(state_q) || (state_q == ERR);
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader. Two instances share all stimulus: one with
// BASE_ADDR 0000 and one with BASE_ADDR FFFF (address wrap). Frames are
// pushed into a reference model that predicts each write as
// (base + word index, word); a negedge monitor pops and compares on every
// write pulse.
module tb_instr_loader;
  import cpu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        rx_ready0, rx_ready1;
  logic [15:0] addr0, addr1, data0, data1, words0, words1;
  logic        wen0, wen1, hold0, hold1, done0, done1, err0, err1;
  loader_state_e st0, st1;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [15:0] frame_words[$];
  logic        prev_wen0 = 1'b0;
  logic        prev_wen1 = 1'b0;

  instr_loader #(.BASE_ADDR(16'h0000)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready0), .instr_addr2(addr0),
    .instr_data2(data0), .instr_Wen2(wen0), .cpu_hold(hold0),
    .load_done(done0), .load_err(err0), .words_loaded(words0),
    .dbg_state(st0)
  );

  instr_loader #(.BASE_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready1), .instr_addr2(addr1),
    .instr_data2(data1), .instr_Wen2(wen1), .cpu_hold(hold1),
    .load_done(done1), .load_err(err1), .words_loaded(words1),
    .dbg_state(st1)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: compare every write pulse against the scoreboard queues and
  // flag adjacent pulses.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_wen0 = 1'b0;
      prev_wen1 = 1'b0;
    end else begin
      if (wen0) begin
        if (exp0_q.size() == 0) fail_now("wr0_unexpected");
        else chk("wr0_addr_data", {addr0, data0}, exp0_q.pop_front());
        if (prev_wen0) fail_now("wr0_adjacent_pulse");
      end
      if (wen1) begin
        if (exp1_q.size() == 0) fail_now("wr1_unexpected");
        else chk("wr1_addr_data", {addr1, data1}, exp1_q.pop_front());
        if (prev_wen1) fail_now("wr1_adjacent_pulse");
      end
      prev_wen0 = wen0;
      prev_wen1 = wen1;
    end
  end

  // Driver tasks: all run from #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int budget;
    rx_valid = 1'b0;
    if (gappy) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    budget   = 0;
    while (!rx_ready0 && budget < 20) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (!rx_ready0) fail_now("rx_ready_timeout");
    else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit gappy);
    send_byte(w[15:8], gappy);
    send_byte(w[7:0], gappy);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end();
    int budget;
    budget = 0;
    while (st0 != DONE && st0 != ERR && budget < 40) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (st0 != DONE && st0 != ERR) fail_now("end_of_frame_timeout");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_end(input string tag, input bit ok, input logic [15:0] nwords);
    chk({tag, "_done0"}, 32'(done0), 32'(ok));
    chk({tag, "_err0"},  32'(err0),  32'(!ok));
    chk({tag, "_hold0"}, 32'(hold0), 32'(!ok));
    chk({tag, "_words0"}, 32'(words0), 32'(nwords));
    chk({tag, "_done1"}, 32'(done1), 32'(ok));
    chk({tag, "_words1"}, 32'(words1), 32'(nwords));
    chk({tag, "_q0_drained"}, 32'(exp0_q.size()), 32'd0);
    chk({tag, "_q1_drained"}, 32'(exp1_q.size()), 32'd0);
  endtask

  // Reference model + stimulus for one complete frame held in frame_words.
  task automatic run_frame(input string tag, input bit bad, input bit gappy, input bit mid_start);
    logic [15:0] sum;
    logic [15:0] len;
    logic [15:0] idx;
    sum = 16'h0000;
    len = 16'(frame_words.size());
    for (int i = 0; i < frame_words.size(); i++) begin
      idx = 16'(i);
      exp0_q.push_back({16'h0000 + idx, frame_words[i]});
      exp1_q.push_back({16'hFFFF + idx, frame_words[i]});
      sum = sum + frame_words[i];
    end
    pulse_start();
    send_word(len, gappy);
    for (int i = 0; i < frame_words.size(); i++) begin
      if (mid_start && i == 1) pulse_start();
      send_word(frame_words[i], gappy);
    end
    send_word(bad ? sum + 16'd1 : sum, gappy);
    wait_end();
    check_end(tag, !bad, len);
  endtask

  // Main sequence
  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(st0), 32'(IDLE));
    chk("rst_outs0", {addr0, data0}, 32'h0);
    chk("rst_flags0", {27'd0, wen0, hold0, done0, err0, rx_ready0}, 32'h0);
    chk("rst_words0", 32'(words0), 32'h0);
    chk("rst_outs1", {addr1, data1}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of DATA, after 2 of 4 words were written.
    exp0_q.push_back({16'h0000, 16'h1111});
    exp0_q.push_back({16'h0001, 16'h2222});
    exp1_q.push_back({16'hFFFF, 16'h1111});
    exp1_q.push_back({16'h0000, 16'h2222});
    pulse_start();
    send_word(16'd4, 1'b0);
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("middata_state", 32'(st0), 32'(DATA));
    chk("middata_words", 32'(words0), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_state", 32'(st0), 32'(IDLE));
    chk("midrst_flags", {28'd0, wen0, hold0, rx_ready0, done0}, 32'h0);
    chk("midrst_words", 32'(words0), 32'h0);
    chk("midrst_q0_drained", 32'(exp0_q.size()), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Three-word frame, correct checksum.
    frame_words = '{16'h1234, 16'hABCD, 16'h0001};
    run_frame("f3_good", 1'b0, 1'b0, 1'b0);

    // Same frame, checksum off by one.
    run_frame("f3_bad", 1'b1, 1'b0, 1'b0);
    chk("f3_bad_state", 32'(st0), 32'(ERR));

    // Recovery with a one-word frame.
    frame_words = '{16'h0005};
    run_frame("f1_good", 1'b0, 1'b0, 1'b0);

    // Empty frame.
    frame_words = {};
    run_frame("f0_good", 1'b0, 1'b0, 1'b0);

    // Oversized length aborts right after the second LEN byte.
    pulse_start();
    send_word(16'd4097, 1'b0);
    chk("ovf_state", 32'(st0), 32'(ERR));
    chk("ovf_flags", {28'd0, err0, hold0, rx_ready0, done0}, 32'b1100);
    chk("ovf_words", 32'(words0), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("ovf_q0_drained", 32'(exp0_q.size()), 32'd0);

    // Gappy stream with a start pulse during DATA.
    frame_words = {};
    for (int i = 0; i < 4; i++) frame_words.push_back(16'($urandom));
    run_frame("gap_midstart", 1'b0, 1'b1, 1'b1);

    // Randomised frames.
    for (int k = 0; k < 8; k++) begin
      frame_words = {};
      repeat ($urandom_range(1, 6)) frame_words.push_back(16'($urandom));
      run_frame($sformatf("rnd%0d", k), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
